// File: rtl/aes_result_checker_pkg.sv
// Shared definitions for the AES RAM result checker: FSM state encodings and
// default region layout of the dual-port RAM.
package aes_result_checker_pkg;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_READ  = 2'd1;
   localparam logic [1:0] ST_DRAIN = 2'd2;
   localparam logic [1:0] ST_DONE  = 2'd3;

   localparam int unsigned DEF_ADDR_WIDTH  = 8;
   localparam int unsigned DEF_DATA_WIDTH  = 32;
   localparam logic [7:0]  DEF_PLAIN_BASE  = 8'h00;
   localparam logic [7:0]  DEF_RESULT_BASE = 8'h80;
   localparam int unsigned DEF_NUM_WORDS   = 128;

endpackage

// File: rtl/aes_result_checker_addr_sequencer.sv
// Offset counter for the result checker: produces both region addresses
// (base + offset, wrapping) and flags once the last offset has been issued.
module aes_result_checker_addr_sequencer
   import aes_result_checker_pkg::*;
#(
   parameter int unsigned                ADDR_WIDTH  = DEF_ADDR_WIDTH,
   parameter logic [ADDR_WIDTH-1:0]      PLAIN_BASE  = ADDR_WIDTH'(DEF_PLAIN_BASE),
   parameter logic [ADDR_WIDTH-1:0]      RESULT_BASE = ADDR_WIDTH'(DEF_RESULT_BASE),
   parameter int unsigned                NUM_WORDS   = DEF_NUM_WORDS
)(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  i_start,
   input  logic                  i_advance,
   output logic [ADDR_WIDTH-1:0] o_addr_a,
   output logic [ADDR_WIDTH-1:0] o_addr_b,
   output logic [ADDR_WIDTH-1:0] o_offset,
   output logic                  o_done
);

   localparam logic [ADDR_WIDTH-1:0] LAST_OFF = ADDR_WIDTH'(NUM_WORDS - 1);

   logic [ADDR_WIDTH-1:0] r_offset;
   logic                  r_done;

   // The offset parks on the last value instead of wrapping, so a full
   // 2^ADDR_WIDTH run never needs a wider counter.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_offset <= '0;
         r_done   <= 1'b0;
      end else if (i_start) begin
         r_offset <= '0;
         r_done   <= 1'b0;
      end else if (i_advance && !r_done) begin
         if (r_offset == LAST_OFF) begin
            r_done <= 1'b1;
         end else begin
            r_offset <= r_offset + 1'b1;
         end
      end
   end

   assign o_addr_a = PLAIN_BASE + r_offset;
   assign o_addr_b = RESULT_BASE + r_offset;
   assign o_offset = r_offset;
   assign o_done   = r_done;

endmodule

// File: rtl/aes_result_checker.sv
// Compares the plaintext and decrypted RAM regions word by word after
// decryption finishes. Optional macro: CHECKER_STOP_ON_FIRST_EN.
module aes_result_checker
   import aes_result_checker_pkg::*;
#(
   parameter int unsigned           ADDR_WIDTH  = DEF_ADDR_WIDTH,
   parameter int unsigned           DATA_WIDTH  = DEF_DATA_WIDTH,
   parameter logic [ADDR_WIDTH-1:0] PLAIN_BASE  = ADDR_WIDTH'(DEF_PLAIN_BASE),
   parameter logic [ADDR_WIDTH-1:0] RESULT_BASE = ADDR_WIDTH'(DEF_RESULT_BASE),
   parameter int unsigned           NUM_WORDS   = DEF_NUM_WORDS
)(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  ena,
   output logic [ADDR_WIDTH-1:0] addrA,
   output logic [ADDR_WIDTH-1:0] addrB,
   input  logic [DATA_WIDTH-1:0] data_inA,
   input  logic [DATA_WIDTH-1:0] data_inB,
   output logic                  finished,
   output logic                  pass,
   output logic [ADDR_WIDTH:0]   mismatch_count,
   output logic [ADDR_WIDTH-1:0] first_mismatch,
   output logic [1:0]            o_dbg_state
);

   logic [1:0]            r_state;
   logic [ADDR_WIDTH-1:0] r_addr_a;
   logic [ADDR_WIDTH-1:0] r_addr_b;
   logic                  r_iss_valid;
   logic [ADDR_WIDTH-1:0] r_iss_off;
   logic                  r_cmp_valid;
   logic [ADDR_WIDTH-1:0] r_cmp_off;
   logic [ADDR_WIDTH:0]   r_count;
   logic [ADDR_WIDTH-1:0] r_first;
   logic                  r_finished;
   logic                  r_pass;

   logic                  w_start;
   logic                  w_issue;
   logic                  w_stop;
   logic                  w_mismatch;
   logic                  w_count_en;
   logic [ADDR_WIDTH:0]   w_count_next;
   logic [ADDR_WIDTH-1:0] w_seq_addr_a;
   logic [ADDR_WIDTH-1:0] w_seq_addr_b;
   logic [ADDR_WIDTH-1:0] w_seq_off;
   logic                  w_seq_done;

   aes_result_checker_addr_sequencer #(
      .ADDR_WIDTH  (ADDR_WIDTH),
      .PLAIN_BASE  (PLAIN_BASE),
      .RESULT_BASE (RESULT_BASE),
      .NUM_WORDS   (NUM_WORDS)
   ) u_seq (
      .clk       (clk),
      .rst       (rst),
      .i_start   (w_start),
      .i_advance (w_issue),
      .o_addr_a  (w_seq_addr_a),
      .o_addr_b  (w_seq_addr_b),
      .o_offset  (w_seq_off),
      .o_done    (w_seq_done)
   );

   assign w_start    = (r_state == ST_IDLE) && ena;
   // r_cmp_valid marks the cycle in which the RAM returns data for an issue.
   assign w_mismatch = r_cmp_valid && (data_inA != data_inB);

`ifdef CHECKER_STOP_ON_FIRST_EN
   assign w_stop     = w_mismatch;
   assign w_count_en = w_mismatch && (r_count == '0);
`else
   assign w_stop     = 1'b0;
   assign w_count_en = w_mismatch;
`endif

   assign w_issue = (r_state == ST_READ) && !w_seq_done && !w_stop;

   always_comb begin
      w_count_next = r_count;
      if (w_count_en && !(&r_count)) begin
         w_count_next = r_count + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= ST_IDLE;
      end else begin
         case (r_state)
            ST_IDLE:  if (ena) r_state <= ST_READ;
            ST_READ:  if (!w_issue) r_state <= ST_DRAIN;
            ST_DRAIN: r_state <= ST_DONE;
            ST_DONE:  if (!ena) r_state <= ST_IDLE;
            default:  r_state <= ST_IDLE;
         endcase
      end
   end

   // Address registers drive a wired-OR bus, so they must be zero whenever
   // no issue is in progress.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_addr_a    <= '0;
         r_addr_b    <= '0;
         r_iss_valid <= 1'b0;
         r_iss_off   <= '0;
         r_cmp_valid <= 1'b0;
         r_cmp_off   <= '0;
      end else begin
         r_addr_a    <= w_issue ? w_seq_addr_a : '0;
         r_addr_b    <= w_issue ? w_seq_addr_b : '0;
         r_iss_valid <= w_issue;
         r_iss_off   <= w_seq_off;
         r_cmp_valid <= r_iss_valid;
         r_cmp_off   <= r_iss_off;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_count    <= '0;
         r_first    <= '0;
         r_pass     <= 1'b0;
         r_finished <= 1'b0;
      end else if (w_start) begin
         r_count    <= '0;
         r_first    <= '0;
         r_pass     <= 1'b0;
         r_finished <= 1'b0;
      end else begin
         r_count <= w_count_next;
         if (w_mismatch && (r_count == '0)) begin
            r_first <= r_cmp_off;
         end
         if (r_state == ST_DRAIN) begin
            r_pass     <= (w_count_next == '0);
            r_finished <= 1'b1;
         end else if ((r_state == ST_DONE) && !ena) begin
            r_finished <= 1'b0;
         end
      end
   end

   assign addrA          = r_addr_a;
   assign addrB          = r_addr_b;
   assign finished       = r_finished;
   assign pass           = r_pass;
   assign mismatch_count = r_count;
   assign first_mismatch = r_first;
   assign o_dbg_state    = r_state;

endmodule
